// File: rtl/rmii_mac_tx.sv
`default_nettype none
// ============================================================================
//  Module   : rmii_mac_tx
//  Purpose  : RMII 100 Mb/s transmit framer (preamble/SFD, payload, pad,
//             CRC-32 FCS, inter-frame gap), one dibit per REF_CLK.
//  Revision : 1.0  initial release
// ============================================================================
module rmii_mac_tx #(
    parameter int IFG_BYTES = 12,
    parameter int MIN_FRAME = 60,
    parameter int PAD_EN    = 1,
    parameter int FCS_EN    = 1
) (
    input  logic       REF_CLK,
    input  logic       rst,
    input  logic [7:0] s_tdata,
    input  logic       s_tvalid,
    input  logic       s_tlast,
    output logic       s_tready,
    output logic       TX_EN,
    output logic       TXD0,
    output logic       TXD1,
    output logic       busy,
    output logic       underrun
);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_PRE  = 3'd1;
    localparam logic [2:0] c_DATA = 3'd2;
    localparam logic [2:0] c_PAD  = 3'd3;
    localparam logic [2:0] c_FCS  = 3'd4;
    localparam logic [2:0] c_IFG  = 3'd5;

    localparam int c_IFG_CLKS = IFG_BYTES * 4;
    localparam int c_CNT_MAX  = (c_IFG_CLKS > 32) ? c_IFG_CLKS : 32;
    localparam int c_CNT_W    = $clog2(c_CNT_MAX);
    localparam int c_BYTE_W   = $clog2(MIN_FRAME + 1);

    localparam logic [c_CNT_W-1:0]  c_PRE_LAST  = c_CNT_W'(31);
    localparam logic [c_CNT_W-1:0]  c_BYTE_LAST = c_CNT_W'(3);
    localparam logic [c_CNT_W-1:0]  c_FCS_LAST  = c_CNT_W'(15);
    // The IDLE clock that follows IFG is also a silent wire clock, so IFG itself
    // runs one clock short; an aborted frame already lost its ready clock, so it
    // enters IFG one count further on.
    localparam logic [c_CNT_W-1:0]  c_IFG_LAST  = c_CNT_W'(c_IFG_CLKS - 2);
    localparam logic [c_CNT_W-1:0]  c_IFG_ABORT = c_CNT_W'(1);
    localparam logic [c_BYTE_W-1:0] c_MIN       = c_BYTE_W'(MIN_FRAME);
    localparam logic [31:0]         c_POLY      = 32'hEDB88320;

    logic [2:0]          state_q, state_d;
    logic [c_CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]          shift_q, shift_d;
    logic                last_q, last_d;
    logic [c_BYTE_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [31:0]         crc_q, crc_d;
    logic                tx_en_q, tx_en_d;
    logic [1:0]          txd_q, txd_d;
    logic                underrun_q, underrun_d;

    logic                w_ready;
    logic [c_BYTE_W-1:0] w_byte_inc;
    logic [2:0]          w_after;

    function automatic logic [31:0] crc_dibit(input logic [31:0] crc, input logic [1:0] d);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 2; i++) begin
            if (c[0] ^ d[i]) c = (c >> 1) ^ c_POLY;
            else             c = c >> 1;
        end
        return c;
    endfunction

    assign w_ready = ((state_q == c_PRE)  && (cnt_q == c_PRE_LAST)) ||
                     ((state_q == c_DATA) && (cnt_q == c_BYTE_LAST) && !last_q);
    assign w_byte_inc = (byte_cnt_q == c_MIN) ? byte_cnt_q : byte_cnt_q + 1'b1;
    assign w_after = ((PAD_EN != 0) && (w_byte_inc < c_MIN)) ? c_PAD :
                     (FCS_EN != 0) ? c_FCS : c_IFG;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        last_d     = last_q;
        byte_cnt_d = byte_cnt_q;
        crc_d      = crc_q;
        tx_en_d    = 1'b0;
        txd_d      = 2'b00;
        underrun_d = 1'b0;
        case (state_q)
            c_IDLE: begin
                cnt_d      = '0;
                byte_cnt_d = '0;
                if (s_tvalid) state_d = c_PRE;
            end
            c_PRE: begin
                tx_en_d    = 1'b1;
                txd_d      = (cnt_q == c_PRE_LAST) ? 2'b11 : 2'b01;
                crc_d      = 32'hFFFF_FFFF;
                byte_cnt_d = '0;
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == c_PRE_LAST) begin
                    cnt_d = '0;
                    if (s_tvalid) begin
                        shift_d = s_tdata;
                        last_d  = s_tlast;
                        state_d = c_DATA;
                    end else begin
                        tx_en_d    = 1'b0;
                        txd_d      = 2'b00;
                        underrun_d = 1'b1;
                        state_d    = c_IFG;
                        cnt_d      = c_IFG_ABORT;
                    end
                end
            end
            c_DATA: begin
                tx_en_d = 1'b1;
                txd_d   = shift_q[1:0];
                shift_d = shift_q >> 2;
                crc_d   = crc_dibit(crc_q, shift_q[1:0]);
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == c_BYTE_LAST) begin
                    byte_cnt_d = w_byte_inc;
                    cnt_d      = '0;
                    if (last_q) begin
                        state_d = w_after;
                    end else if (s_tvalid) begin
                        shift_d = s_tdata;
                        last_d  = s_tlast;
                    end else begin
                        tx_en_d    = 1'b0;
                        txd_d      = 2'b00;
                        underrun_d = 1'b1;
                        state_d    = c_IFG;
                        cnt_d      = c_IFG_ABORT;
                    end
                end
            end
            c_PAD: begin
                tx_en_d = 1'b1;
                crc_d   = crc_dibit(crc_q, 2'b00);
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == c_BYTE_LAST) begin
                    byte_cnt_d = w_byte_inc;
                    cnt_d      = '0;
                    state_d    = w_after;
                end
            end
            c_FCS: begin
                tx_en_d = 1'b1;
                txd_d   = ~crc_q[1:0];
                crc_d   = crc_q >> 2;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == c_FCS_LAST) begin
                    cnt_d   = '0;
                    state_d = c_IFG;
                end
            end
            c_IFG: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == c_IFG_LAST) begin
                    cnt_d   = '0;
                    state_d = c_IDLE;
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    always_ff @(posedge REF_CLK) begin
        if (rst) begin
            state_q    <= c_IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            last_q     <= 1'b0;
            byte_cnt_q <= '0;
            crc_q      <= '0;
            tx_en_q    <= 1'b0;
            txd_q      <= 2'b00;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            last_q     <= last_d;
            byte_cnt_q <= byte_cnt_d;
            crc_q      <= crc_d;
            tx_en_q    <= tx_en_d;
            txd_q      <= txd_d;
            underrun_q <= underrun_d;
        end
    end

    assign s_tready = w_ready;
    assign TX_EN    = tx_en_q;
    assign TXD0     = txd_q[0];
    assign TXD1     = txd_q[1];
    assign busy     = (state_q != c_IDLE);
    assign underrun = underrun_q;

endmodule
`default_nettype wire
